gemm_tile_data_mover: RTL
=========================

# gemm_tile_data_mover

Parametrised successor to the convolution data mover in the GEMM path. Sequences read-only fetches from the weight memory (mem0) and the activation memory (mem1) to feed a PE_SIZE x PE_SIZE systolic array. Per run it processes a runtime-programmed number of weight tiles; each tile is a PE_SIZE-row weight preload, then an activation stream of runtime length, then a drain gap. It adds a start/done handshake, a stall input and aligned valid/last strobes toward the array.

## Interface
- PE_SIZE, 16, rows per weight tile; also the array dimension.
- MEM0_DATA_WIDTH, 128, weight row width.
- MEM1_DATA_WIDTH, 128, activation row width.
- MEM0_ADDR_WIDTH, 10, weight memory address width.
- MEM1_ADDR_WIDTH, 10, activation memory address width.
- TILE_CNT_WIDTH, 6, width of the tile count and tile index.
- DRAIN_CYCLES, 15, idle cycles after each activation stream; legal range is 1 or more.
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  run request; sampled only in IDLE.
- num_tiles_i  in  TILE_CNT_WIDTH  tile count; latched at start.
- act_len_i  in  MEM1_ADDR_WIDTH+1  activation rows per tile; latched at start.
- mem0_base_i  in  MEM0_ADDR_WIDTH  first weight address; latched at start.
- stall_i  in  1  pause fetches during LOAD_W and STREAM_A.
- mem0_q0  in  MEM0_DATA_WIDTH  weight read data; 1-cycle latency.
- mem0_addr0 / mem0_ce0 / mem0_we0  out  MEM0_ADDR_WIDTH / 1 / 1  weight memory port.
- mem1_q0  in  MEM1_DATA_WIDTH  activation read data; 1-cycle latency.
- mem1_addr0 / mem1_ce0 / mem1_we0  out  MEM1_ADDR_WIDTH / 1 / 1  activation memory port.
- w_data_o / w_valid_o / w_last_o  out  MEM0_DATA_WIDTH / 1 / 1  weight row to the array.
- a_data_o / a_valid_o / a_last_o  out  MEM1_DATA_WIDTH / 1 / 1  activation row to the array.
- tile_idx_o  out  TILE_CNT_WIDTH  index of the current tile.
- busy_o / done_o  out  1 / 1  run in progress / run completed (1-cycle pulse).

## Operation
- States: IDLE, LOAD_W, STREAM_A, DRAIN, DONE.
- IDLE:
  - start_i=1 latches num_tiles, act_len and base; clears the tile, row and drain counters.
  - If num_tiles==0 or act_len==0, next state is DONE; otherwise LOAD_W.
- LOAD_W:
  - mem0_ce0 = !stall_i.
  - mem0_addr0 = base + tile*PE_SIZE + row, truncated to MEM0_ADDR_WIDTH, so it wraps modulo 2^MEM0_ADDR_WIDTH.
  - row advances on each unstalled cycle. At row==PE_SIZE-1 with no stall, row clears and the state moves to STREAM_A.
- STREAM_A:
  - mem1_ce0 = !stall_i; mem1_addr0 = arow.
  - Activations restart at address 0 for every tile.
  - At arow==act_len-1 with no stall, arow clears and the state moves to DRAIN.
  - act_len values above 2^MEM1_ADDR_WIDTH are clamped to 2^MEM1_ADDR_WIDTH.
- DRAIN:
  - Counts DRAIN_CYCLES cycles; stall_i is ignored.
  - At the end: if tile==num_tiles-1, go to DONE; otherwise increment tile and go to LOAD_W.
- DONE: done_o=1 for exactly one cycle, then IDLE.
- mem0_we0 and mem1_we0 are tied to 0.
- Addresses hold their last value when ce is low.
- Data passes through combinationally: w_data_o=mem0_q0, a_data_o=mem1_q0.
- start_i is ignored outside IDLE. Latched config does not change mid-run.

## Timing
- Reset values:
  - state IDLE; all counters 0.
  - mem0_ce0=mem1_ce0=0; mem0_addr0=mem1_addr0=0.
  - w_valid_o=a_valid_o=w_last_o=a_last_o=0.
  - busy_o=done_o=0; tile_idx_o=0.
- Reset asserted mid-run aborts immediately to reset values. No done_o pulse is produced.
- ce outputs are decoded from the state register and stall_i.
- w_valid_o and a_valid_o are the respective ce registered by one cycle, aligned with q0.
- w_last_o marks row PE_SIZE-1; a_last_o marks arow act_len-1. Both are registered alongside valid.
- busy_o=1 in LOAD_W, STREAM_A and DRAIN.
- tile_idx_o is the registered tile counter.
- Start sampled at edge 0:
  - LOAD_W occupies cycles 1..PE_SIZE; STREAM_A follows directly, with no bubble.
  - With no stall, a tile takes PE_SIZE+act_len+DRAIN_CYCLES cycles.
  - done_o occurs at cycle 1 + num_tiles*(PE_SIZE+act_len+DRAIN_CYCLES).
- Each stalled cycle in LOAD_W or STREAM_A adds exactly one cycle and produces one valid=0 bubble on the next cycle.
- A stall on the last row delays the state transition.
- Zero-length run: done_o at cycle 1; busy_o never rises.

## Test plan
- Single tile:
  - Stimulus: PE_SIZE=16, base=0, num_tiles=1, act_len=4, DRAIN=15, no stall.
  - Required: mem0 addresses 0..15 on cycles 1..16; mem1 addresses 0..3 on cycles 17..20.
  - Required: w_valid on cycles 2..17 with w_last at 17; a_last at 21; done_o at cycle 36.
- Multi-tile:
  - Stimulus: base=5, num_tiles=3, act_len=2.
  - Required: weight addresses 5..20, 21..36, 37..52; tile_idx_o 0,1,2; done_o at cycle 100.
- Stall:
  - Stimulus: stall_i=1 for 3 cycles mid-LOAD_W and 2 cycles mid-STREAM_A.
  - Required: no address skipped or repeated; 5 valid bubbles; done_o 5 cycles later than the unstalled run.
- Wrap and clamp:
  - Stimulus: MEM0_ADDR_WIDTH=10, base=1020.
  - Required: weight addresses 1020..1023 then 0..11.
  - Stimulus: act_len=2000.
  - Required: exactly 1024 activation reads.
- Degenerate runs:
  - Stimulus: num_tiles=0 or act_len=0.
  - Required: done_o at cycle 1 with no ce activity.
  - Stimulus: start_i pulsed while busy.
  - Required: ignored; config unchanged.
- Reset mid-STREAM_A:
  - Required: all outputs return to reset values on the next edge; no done_o.
  - Required: a new start afterward runs cleanly from tile 0.

Source files
------------

// File: rtl/gemm_tile_data_mover.sv
// Tile sequencer for the GEMM systolic array: per tile, preloads PE_SIZE weight rows,
// streams act_len activation rows, then idles DRAIN_CYCLES before the next tile.
module gemm_tile_data_mover #(
   parameter int PE_SIZE         = 16,
   parameter int MEM0_DATA_WIDTH = 128,
   parameter int MEM1_DATA_WIDTH = 128,
   parameter int MEM0_ADDR_WIDTH = 10,
   parameter int MEM1_ADDR_WIDTH = 10,
   parameter int TILE_CNT_WIDTH  = 6,
   parameter int DRAIN_CYCLES    = 15
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start_i,
   input  logic [TILE_CNT_WIDTH-1:0]  num_tiles_i,
   input  logic [MEM1_ADDR_WIDTH:0]   act_len_i,
   input  logic [MEM0_ADDR_WIDTH-1:0] mem0_base_i,
   input  logic                       stall_i,
   input  logic [MEM0_DATA_WIDTH-1:0] mem0_q0,
   output logic [MEM0_ADDR_WIDTH-1:0] mem0_addr0,
   output logic                       mem0_ce0,
   output logic                       mem0_we0,
   input  logic [MEM1_DATA_WIDTH-1:0] mem1_q0,
   output logic [MEM1_ADDR_WIDTH-1:0] mem1_addr0,
   output logic                       mem1_ce0,
   output logic                       mem1_we0,
   output logic [MEM0_DATA_WIDTH-1:0] w_data_o,
   output logic                       w_valid_o,
   output logic                       w_last_o,
   output logic [MEM1_DATA_WIDTH-1:0] a_data_o,
   output logic                       a_valid_o,
   output logic                       a_last_o,
   output logic [TILE_CNT_WIDTH-1:0]  tile_idx_o,
   output logic                       busy_o,
   output logic                       done_o
);

   localparam int ROW_W = (PE_SIZE > 1) ? $clog2(PE_SIZE) : 1;
   localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam int LEN_W = MEM1_ADDR_WIDTH + 1;
   localparam logic [LEN_W-1:0] LEN_MAX = {1'b1, {MEM1_ADDR_WIDTH{1'b0}}};

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_LOAD_W   = 3'd1;
   localparam logic [2:0] S_STREAM_A = 3'd2;
   localparam logic [2:0] S_DRAIN    = 3'd3;
   localparam logic [2:0] S_DONE     = 3'd4;

   logic [2:0]                 state;
   logic [TILE_CNT_WIDTH-1:0]  tile;
   logic [ROW_W-1:0]           row;
   logic [MEM1_ADDR_WIDTH-1:0] arow;
   logic [DRN_W-1:0]           drain_cnt;
   logic [TILE_CNT_WIDTH-1:0]  num_tiles_q;
   logic [LEN_W-1:0]           act_len_q;
   logic [MEM0_ADDR_WIDTH-1:0] base_q;
   logic [MEM0_ADDR_WIDTH-1:0] w_addr_q;
   logic [MEM1_ADDR_WIDTH-1:0] a_addr_q;
   logic [MEM0_ADDR_WIDTH-1:0] w_addr_calc;
   logic                       w_valid_q, a_valid_q, w_last_q, a_last_q;
   logic                       row_last, arow_last, drain_last, tile_last;

   assign mem0_ce0 = (state == S_LOAD_W) && !stall_i;
   assign mem1_ce0 = (state == S_STREAM_A) && !stall_i;
   assign mem0_we0 = 1'b0;
   assign mem1_we0 = 1'b0;

   assign row_last   = (row == ROW_W'(PE_SIZE - 1));
   assign arow_last  = ({1'b0, arow} == (act_len_q - LEN_W'(1)));
   assign drain_last = (drain_cnt == DRN_W'(DRAIN_CYCLES - 1));
   assign tile_last  = (tile == (num_tiles_q - TILE_CNT_WIDTH'(1)));

   // Address arithmetic is done at the memory width so it wraps naturally.
   assign w_addr_calc = base_q + MEM0_ADDR_WIDTH'(tile) * MEM0_ADDR_WIDTH'(PE_SIZE)
                        + MEM0_ADDR_WIDTH'(row);

   assign mem0_addr0 = mem0_ce0 ? w_addr_calc : w_addr_q;
   assign mem1_addr0 = mem1_ce0 ? arow : a_addr_q;

   assign w_data_o   = mem0_q0;
   assign a_data_o   = mem1_q0;
   assign w_valid_o  = w_valid_q;
   assign a_valid_o  = a_valid_q;
   assign w_last_o   = w_last_q;
   assign a_last_o   = a_last_q;
   assign tile_idx_o = tile;
   assign busy_o     = (state == S_LOAD_W) || (state == S_STREAM_A) || (state == S_DRAIN);
   assign done_o     = (state == S_DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         tile        <= '0;
         row         <= '0;
         arow        <= '0;
         drain_cnt   <= '0;
         num_tiles_q <= '0;
         act_len_q   <= '0;
         base_q      <= '0;
         w_addr_q    <= '0;
         a_addr_q    <= '0;
         w_valid_q   <= 1'b0;
         a_valid_q   <= 1'b0;
         w_last_q    <= 1'b0;
         a_last_q    <= 1'b0;
      end else begin
         w_valid_q <= mem0_ce0;
         a_valid_q <= mem1_ce0;
         w_last_q  <= mem0_ce0 && row_last;
         a_last_q  <= mem1_ce0 && arow_last;
         if (mem0_ce0) w_addr_q <= w_addr_calc;
         if (mem1_ce0) a_addr_q <= arow;

         case (state)
            S_IDLE: begin
               if (start_i) begin
                  num_tiles_q <= num_tiles_i;
                  act_len_q   <= (act_len_i > LEN_MAX) ? LEN_MAX : act_len_i;
                  base_q      <= mem0_base_i;
                  tile        <= '0;
                  row         <= '0;
                  arow        <= '0;
                  drain_cnt   <= '0;
                  state       <= (num_tiles_i == '0 || act_len_i == '0) ? S_DONE : S_LOAD_W;
               end
            end
            S_LOAD_W: begin
               if (!stall_i) begin
                  if (row_last) begin
                     row   <= '0;
                     state <= S_STREAM_A;
                  end else begin
                     row <= row + ROW_W'(1);
                  end
               end
            end
            S_STREAM_A: begin
               if (!stall_i) begin
                  if (arow_last) begin
                     arow  <= '0;
                     state <= S_DRAIN;
                  end else begin
                     arow <= arow + MEM1_ADDR_WIDTH'(1);
                  end
               end
            end
            S_DRAIN: begin
               if (drain_last) begin
                  drain_cnt <= '0;
                  if (tile_last) begin
                     state <= S_DONE;
                  end else begin
                     tile  <= tile + TILE_CNT_WIDTH'(1);
                     state <= S_LOAD_W;
                  end
               end else begin
                  drain_cnt <= drain_cnt + DRN_W'(1);
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
